// File: rtl/seq_multiplier_pkg.sv
// Shared widths and FSM encoding for the sequential multiplier and its write-back path.
package seq_multiplier_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StWb   = S_WB
  } mult_state_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator, and final sign correction.
// The product output already includes the addend of the current step, so the
// controller can capture the final result on the last RUN edge.
module mult_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_d;

  // Magnitudes of the incoming operands and the next accumulator / signed product.
  always_comb begin
    mag_a   = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    mag_b   = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    product = neg_q ? (~acc_d + 1'b1) : acc_d;
  end

  // Operand latch on load; one multiplier bit consumed per step, LSB first.
  always_ff @(posedge clock) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      acc_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with a held write-back request for the shared
// register-file write port. Low word is written back, high word kept in hi_out.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [REG_IDX_W-1:0] dest,
  input  logic                 wb_grant,
  output logic                 busy,
  output logic                 wb_we,
  output logic [REG_IDX_W-1:0] wb_sel,
  output logic [WIDTH-1:0]     wb_data,
  output logic [WIDTH-1:0]     hi_out
);

  mult_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [REG_IDX_W-1:0] dest_q;
  logic [2*WIDTH-1:0]   product;
  logic                 load;
  logic                 step;
  logic                 last;

  // Datapath handshakes decoded from the current state.
  always_comb begin
    load = (state_q == StIdle) && start;
    step = (state_q == StRun);
    last = (cnt_q == CNT_W'(WIDTH - 1));
  end

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock    (clock),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .is_signed(is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .product  (product)
  );

  // Control FSM, iteration counter and registered write-back outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dest_q  <= '0;
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_sel  <= '0;
      wb_data <= '0;
      hi_out  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            cnt_q   <= '0;
            dest_q  <= dest;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_out  <= product[2*WIDTH-1:WIDTH];
            wb_data <= product[WIDTH-1:0];
            // Register 0 is never written; finish silently.
            if (dest_q != '0) begin
              state_q <= StWb;
              wb_we   <= 1'b1;
              wb_sel  <= dest_q;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        StWb: begin
          if (wb_grant) begin
            state_q <= StIdle;
            wb_we   <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          wb_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table, corner sequences, random ops.
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  dest = '0;
  logic        wb_grant = 1'b0;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic [31:0] hi_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;

  seq_multiplier dut (
    .clock    (clock),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .dest     (dest),
    .wb_grant (wb_grant),
    .busy     (busy),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_data  (wb_data),
    .hi_out   (hi_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Present a start for one cycle; t_start marks the accepting edge.
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
    @(posedge clock); #1;
    start = 1'b1; is_signed = s; op_a = a; op_b = b; dest = d;
    @(posedge clock); #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  // Observe one operation to completion. lat counts cycles after the start edge.
  task automatic collect(input string nm, input logic [4:0] d, input int stall,
                         input logic [63:0] exp);
    int lat;
    int held;
    int extra;
    int unstable;
    bit any_we;
    wb_grant = (stall == 0);
    lat = 0;
    if (d == 5'd0) begin
      any_we = 1'b0;
      while (lat < 33) begin
        @(negedge clock);
        lat = cyc - t_start + 1;
        if (wb_we) any_we = 1'b1;
        if (lat == 32) chk({nm, " busy_run"}, 64'(busy), 64'd1);
      end
      chk({nm, " busy_done"}, 64'(busy), 64'd0);
      chk({nm, " no_we"}, 64'(any_we), 64'd0);
      chk({nm, " hi"}, 64'(hi_out), 64'(exp[63:32]));
    end else begin
      do begin
        @(negedge clock);
        lat = cyc - t_start + 1;
      end while (!wb_we && lat < 60);
      chk({nm, " latency"}, 64'(lat), 64'd33);
      chk({nm, " sel"}, 64'(wb_sel), 64'(d));
      chk({nm, " lo"}, 64'(wb_data), 64'(exp[31:0]));
      chk({nm, " hi"}, 64'(hi_out), 64'(exp[63:32]));
      held = 0;
      unstable = 0;
      while (wb_we && held < 40) begin
        held++;
        if (wb_sel !== d || wb_data !== exp[31:0] || busy !== 1'b1) unstable++;
        if (held > stall) wb_grant = 1'b1;
        @(negedge clock);
      end
      chk({nm, " held"}, 64'(held), 64'(stall + 1));
      chk({nm, " stable"}, 64'(unstable), 64'd0);
      chk({nm, " busy_after"}, 64'(busy), 64'd0);
      wb_grant = 1'b0;
      extra = 0;
      repeat (10) begin
        @(negedge clock);
        if (wb_we) extra++;
      end
      chk({nm, " no_extra"}, 64'(extra), 64'd0);
    end
  endtask

  vec_t vecs[$];
  logic [63:0] e;

  initial begin
    vecs.push_back('{0, 32'd7,          32'd6,          5'd3,  0, 64'h0000_0000_0000_002A});
    vecs.push_back('{1, 32'hFFFF_FFFD,  32'd5,          5'd1,  0, 64'hFFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{0, 32'hFFFF_FFFD,  32'd5,          5'd2,  0, 64'h0000_0004_FFFF_FFF1});
    vecs.push_back('{0, 32'h0001_0000,  32'h0001_0000,  5'd9,  5, 64'h0000_0001_0000_0000});
    vecs.push_back('{0, 32'd2,          32'd2,          5'd0,  0, 64'h0000_0000_0000_0004});
    vecs.push_back('{1, 32'h8000_0000,  32'h8000_0000,  5'd5,  1, 64'h4000_0000_0000_0000});
    vecs.push_back('{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{1, 32'd0,          32'hFFFF_FFFF,  5'd31, 0, 64'h0000_0000_0000_0000});
    vecs.push_back('{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  2, 64'h0000_0000_0000_0001});
    vecs.push_back('{1, 32'h7FFF_FFFF,  32'h8000_0000,  5'd8,  0, 64'hC000_0000_8000_0000});

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst we", 64'(wb_we), 64'd0);
    chk("rst sel", 64'(wb_sel), 64'd0);
    chk("rst data", 64'(wb_data), 64'd0);
    chk("rst hi", 64'(hi_out), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].d);
      collect($sformatf("vec%0d", i), vecs[i].d, vecs[i].stall, vecs[i].exp);
    end

    // Start while busy: second request mid-RUN must be dropped.
    launch(1'b0, 32'd7, 32'd6, 5'd3);
    repeat (9) @(negedge clock);
    start = 1'b1; op_a = 32'd1; op_b = 32'd1; dest = 5'd4;
    @(negedge clock);
    start = 1'b0;
    collect("busy_start", 5'd3, 0, 64'd42);

    // Reset in the middle of RUN, then a clean operation.
    launch(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9);
    while (cyc - t_start + 1 < 15) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst we", 64'(wb_we), 64'd0);
    chk("midrst hi", 64'(hi_out), 64'd0);
    launch(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd1);
    collect("after_rst", 5'd1, 0, 64'hFFFF_FFFF_FFFF_FFF1);

    // Random operations against the arithmetic reference.
    for (int n = 0; n < 16; n++) begin
      bit          rs;
      logic [31:0] ra, rb;
      logic [4:0]  rd;
      int          rstall;
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) ra[31] = 1'b1;
      rd = 5'($urandom_range(0, 31));
      rstall = $urandom_range(0, 3);
      e = model(rs, ra, rb);
      launch(rs, ra, rb, rd);
      collect($sformatf("rand%0d", n), rd, rstall, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
